// File: rtl/taus_pkg.sv
// Shared constants, state type and helper functions for the taus88 generator.
// All lanes and the top level use these definitions.
package taus_pkg;

   localparam logic [31:0] MIN_S0  = 32'd2;
   localparam logic [31:0] MIN_S1  = 32'd8;
   localparam logic [31:0] MIN_S2  = 32'd16;

   localparam logic [31:0] MASK_S0 = 32'hFFFF_FFFE;
   localparam logic [31:0] MASK_S1 = 32'hFFFF_FFF8;
   localparam logic [31:0] MASK_S2 = 32'hFFFF_FFF0;

   // (inner left shift, right shift, masked left shift) per component
   localparam int unsigned S0_SH_A = 32'd13;
   localparam int unsigned S0_SH_B = 32'd19;
   localparam int unsigned S0_SH_C = 32'd12;
   localparam int unsigned S1_SH_A = 32'd2;
   localparam int unsigned S1_SH_B = 32'd25;
   localparam int unsigned S1_SH_C = 32'd4;
   localparam int unsigned S2_SH_A = 32'd3;
   localparam int unsigned S2_SH_B = 32'd11;
   localparam int unsigned S2_SH_C = 32'd17;

   typedef struct packed {
      logic [31:0] s0;
      logic [31:0] s1;
      logic [31:0] s2;
   } taus_state_t;

   typedef enum logic [0:0] {
      ST_UNSEEDED = 1'b0,
      ST_RUN      = 1'b1
   } taus_fsm_t;

   function automatic logic [31:0] taus_comp(input logic [31:0] s, input logic [31:0] mask,
                                             input int unsigned sh_a, input int unsigned sh_b,
                                             input int unsigned sh_c);
      return ((s & mask) << sh_c) ^ (((s << sh_a) ^ s) >> sh_b);
   endfunction

   // A component below its minimum would lock the generator into a short cycle.
   function automatic logic [31:0] seed_fix(input logic [31:0] s, input logic [31:0] min_v);
      return (s < min_v) ? (s | min_v) : s;
   endfunction

endpackage

// File: rtl/taus_lane.sv
// One generator lane: combinational taus88 step and seed correction.
// The state register lives in the top level.
module taus_lane
   import taus_pkg::*;
(
   input  taus_state_t i_state,
   input  taus_state_t i_seed,
   output taus_state_t o_next,
   output taus_state_t o_seed_fixed,
   output logic [31:0] o_sample
);

   assign o_next.s0 = taus_comp(i_state.s0, MASK_S0, S0_SH_A, S0_SH_B, S0_SH_C);
   assign o_next.s1 = taus_comp(i_state.s1, MASK_S1, S1_SH_A, S1_SH_B, S1_SH_C);
   assign o_next.s2 = taus_comp(i_state.s2, MASK_S2, S2_SH_A, S2_SH_B, S2_SH_C);
   assign o_sample  = o_next.s0 ^ o_next.s1 ^ o_next.s2;

   assign o_seed_fixed.s0 = seed_fix(i_seed.s0, MIN_S0);
   assign o_seed_fixed.s1 = seed_fix(i_seed.s1, MIN_S1);
   assign o_seed_fixed.s2 = seed_fix(i_seed.s2, MIN_S2);

endmodule

// File: rtl/taus_urng_multi.sv
// Multi-lane taus88 uniform RNG: per-lane seeding, lock-step advance and a
// registered valid/ready sample output holding one 32-bit word per lane.
module taus_urng_multi
   import taus_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  seed_valid,
   output logic                  seed_ready,
   input  logic [LANE_W-1:0]     seed_lane,
   input  logic [31:0]           seed_s0,
   input  logic [31:0]           seed_s1,
   input  logic [31:0]           seed_s2,
   input  logic                  gen_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*32-1:0]   out_data,
   output logic                  all_seeded,
   output logic [31:0]           sample_cnt
);

   taus_fsm_t             r_state;
   taus_fsm_t             w_state_nxt;
   logic                  r_seed_ready;
   logic [LANES-1:0]      r_seeded;
   logic [LANES-1:0]      w_seeded_nxt;
   logic [LANES-1:0]      w_hit;
   logic                  w_seed_acc;
   logic                  w_adv;
   logic                  r_out_valid;
   logic [LANES*32-1:0]   r_out_data;
   logic [LANES*32-1:0]   w_sample;
   logic [31:0]           r_sample_cnt;
   taus_state_t           w_seed_in;

   assign w_seed_acc   = seed_valid && r_seed_ready;
   assign w_seed_in    = '{s0: seed_s0, s1: seed_s1, s2: seed_s2};
   assign w_adv        = (r_state == ST_RUN) && gen_en && (!r_out_valid || out_ready);
   assign w_seeded_nxt = r_seeded | w_hit;

   // Out-of-range lane indices match no lane, so such writes are dropped.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      taus_state_t r_lane;
      taus_state_t w_next;
      taus_state_t w_fixed;

      assign w_hit[k] = w_seed_acc && (32'(seed_lane) == 32'(k));

      taus_lane u_lane (
         .i_state      (r_lane),
         .i_seed       (w_seed_in),
         .o_next       (w_next),
         .o_seed_fixed (w_fixed),
         .o_sample     (w_sample[32*k +: 32])
      );

      // A seed write outranks the step on the same lane.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_lane <= '0;
         end else if (w_hit[k]) begin
            r_lane <= w_fixed;
         end else if (w_adv) begin
            r_lane <= w_next;
         end
      end
   end

   // Next-state: leave UNSEEDED once the write completing the mask lands.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_UNSEEDED: begin
            if (&w_seeded_nxt) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_UNSEEDED;
            end
         end
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_UNSEEDED;
      endcase
   end

   // Control state, output register and accepted-sample counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_UNSEEDED;
         r_seed_ready <= 1'b0;
         r_seeded     <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_sample_cnt <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_seed_ready <= 1'b1;
         r_seeded     <= w_seeded_nxt;
         if (w_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sample;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (r_out_valid && out_ready) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
         end
      end
   end

   assign seed_ready = r_seed_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign sample_cnt = r_sample_cnt;
   assign all_seeded = (r_state == ST_RUN);

endmodule

// File: tb/tb_taus_urng_multi.sv
// Self-checking bench: cycle scoreboard on a 4-lane instance plus a
// seed-vector table and hand sequences on a 1-lane instance.
module tb_taus_urng_multi;

   localparam int L = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, seed_valid, seed_ready, gen_en, out_valid, out_ready, all_seeded;
   logic [2:0]    seed_lane;
   logic [31:0]   seed_s0, seed_s1, seed_s2, sample_cnt;
   logic [127:0]  out_data;

   logic          d1_reset, d1_seed_valid, d1_seed_ready, d1_gen_en, d1_out_valid, d1_out_ready, d1_all_seeded;
   logic [0:0]    d1_seed_lane;
   logic [31:0]   d1_seed_s0, d1_seed_s1, d1_seed_s2, d1_sample_cnt, d1_out_data;

   taus_urng_multi #(.LANES(4), .LANE_W(3)) u_dut (
      .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_ready(seed_ready),
      .seed_lane(seed_lane), .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2),
      .gen_en(gen_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .all_seeded(all_seeded), .sample_cnt(sample_cnt)
   );

   taus_urng_multi #(.LANES(1)) u_dut1 (
      .clk(clk), .reset(d1_reset), .seed_valid(d1_seed_valid), .seed_ready(d1_seed_ready),
      .seed_lane(d1_seed_lane), .seed_s0(d1_seed_s0), .seed_s1(d1_seed_s1), .seed_s2(d1_seed_s2),
      .gen_en(d1_gen_en), .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
      .all_seeded(d1_all_seeded), .sample_cnt(d1_sample_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] fix(input logic [31:0] v, input logic [31:0] lo);
      return (v < lo) ? (v | lo) : v;
   endfunction
   function automatic logic [31:0] st0(input logic [31:0] s);
      return ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
   endfunction
   function automatic logic [31:0] st1(input logic [31:0] s);
      return ((s & 32'hFFFFFFF8) << 4) ^ (((s << 2) ^ s) >> 25);
   endfunction
   function automatic logic [31:0] st2(input logic [31:0] s);
      return ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3) ^ s) >> 11);
   endfunction
   function automatic logic [31:0] first_sample(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return st0(fix(a, 32'd2)) ^ st1(fix(b, 32'd8)) ^ st2(fix(c, 32'd16));
   endfunction

   // Reference model of the 4-lane instance
   logic [31:0]   m_s0[L], m_s1[L], m_s2[L];
   logic [L-1:0]  m_mask;
   logic          m_run, m_valid, m_rdy;
   logic [31:0]   m_cnt;
   logic [127:0]  q[$];
   int            n_pop;

   task automatic model_reset();
      for (int k = 0; k < L; k++) begin
         m_s0[k] = 32'd0; m_s1[k] = 32'd0; m_s2[k] = 32'd0;
      end
      m_mask = '0; m_run = 1'b0; m_valid = 1'b0; m_rdy = 1'b0; m_cnt = 32'd0;
      q.delete(); n_pop = 0;
   endtask

   // Called at a negedge with inputs already set: check, predict, advance one clock.
   task automatic cyc();
      logic [127:0] smp;
      logic [L-1:0] hit;
      logic         adv;
      chk("out_valid", out_valid, m_valid);
      chk("all_seeded", all_seeded, m_run);
      chk("sample_cnt", sample_cnt, m_cnt);
      chk("seed_ready", seed_ready, m_rdy);
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got sample %h with no expected entry", out_data);
         end else begin
            chk("sample", out_data, q.pop_front());
            n_pop++;
         end
      end
      if (reset) begin
         model_reset();
      end else begin
         adv = m_run && gen_en && (!m_valid || out_ready);
         hit = '0;
         smp = '0;
         for (int k = 0; k < L; k++) begin
            if (seed_valid && m_rdy && (int'(seed_lane) == k)) hit[k] = 1'b1;
            smp[32*k +: 32] = st0(m_s0[k]) ^ st1(m_s1[k]) ^ st2(m_s2[k]);
            if (hit[k]) begin
               m_s0[k] = fix(seed_s0, 32'd2); m_s1[k] = fix(seed_s1, 32'd8); m_s2[k] = fix(seed_s2, 32'd16);
            end else if (adv) begin
               m_s0[k] = st0(m_s0[k]); m_s1[k] = st1(m_s1[k]); m_s2[k] = st2(m_s2[k]);
            end
         end
         if (adv) q.push_back(smp);
         if (m_valid && out_ready) m_cnt = m_cnt + 32'd1;
         if (adv) m_valid = 1'b1;
         else if (m_valid && out_ready) m_valid = 1'b0;
         m_mask = m_mask | hit;
         if (&m_mask) m_run = 1'b1;
         m_rdy = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic seed4(input logic [2:0] ln, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      seed_valid = 1'b1; seed_lane = ln; seed_s0 = a; seed_s1 = b; seed_s2 = c;
      cyc();
      seed_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] s0, s1, s2;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[5];

   logic [127:0] hold;
   logic [31:0]  exp2, t0, t1, t2;

   initial begin
      reset = 1'b1; seed_valid = 1'b0; seed_lane = 3'd0; seed_s0 = 32'd0; seed_s1 = 32'd0; seed_s2 = 32'd0;
      gen_en = 1'b0; out_ready = 1'b0;
      d1_reset = 1'b1; d1_seed_valid = 1'b0; d1_seed_lane = 1'b0; d1_seed_s0 = 32'd0; d1_seed_s1 = 32'd0;
      d1_seed_s2 = 32'd0; d1_gen_en = 1'b0; d1_out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      cyc();
      chk("rst_data", out_data, 128'd0);

      // Partial seeding, with an out-of-range write slipped in after lane 1
      reset = 1'b0; gen_en = 1'b1; out_ready = 1'b1;
      cyc();
      seed4(3'd0, 32'd0, 32'd0, 32'd0);
      seed4(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);
      seed4(3'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D);
      seed4(3'd2, 32'd1, 32'd7, 32'd15);
      cyc(); cyc();
      chk("partial_valid", out_valid, 1'b0);
      chk("partial_seeded", all_seeded, 1'b0);
      seed4(3'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0011);
      chk("seed3_run", all_seeded, 1'b1);
      chk("seed3_valid", out_valid, 1'b0);
      cyc();
      chk("first_valid", out_valid, 1'b1);

      // Backpressure hold for 5 cycles
      out_ready = 1'b0;
      hold = out_data;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_hold", out_data, hold);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         gen_en = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      // Lane 2 reseed colliding with an advance
      gen_en = 1'b1; out_ready = 1'b1;
      cyc(); cyc();
      exp2 = first_sample(32'd5, 32'd3, 32'd200);
      seed4(3'd2, 32'd5, 32'd3, 32'd200);
      cyc();
      chk("collide_lane2", out_data[95:64], exp2);

      // Reset mid-stream
      cyc();
      reset = 1'b1;
      cyc();
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_data", out_data, 128'd0);
      chk("mrst_cnt", sample_cnt, 32'd0);
      chk("mrst_seeded", all_seeded, 1'b0);
      chk("mrst_ready", seed_ready, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_seeded", all_seeded, 1'b0);

      // Long random run with occasional reseeds
      for (int k = 0; k < L; k++) seed4(3'(k), $urandom, $urandom, $urandom);
      for (int i = 0; i < 3000; i++) begin
         gen_en = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 99) == 0) begin
            seed_valid = 1'b1; seed_lane = 3'($urandom_range(0, 5));
            seed_s0 = $urandom_range(0, 3); seed_s1 = $urandom; seed_s2 = $urandom_range(0, 20);
         end else begin
            seed_valid = 1'b0;
         end
         cyc();
      end
      seed_valid = 1'b0; gen_en = 1'b0; out_ready = 1'b1;
      cyc(); cyc();
      chk("cnt_total", sample_cnt, 32'(n_pop));

      // Single-lane instance: known zero-seed sequence
      @(negedge clk);
      chk("d1_rst_valid", d1_out_valid, 1'b0);
      chk("d1_rst_ready", d1_seed_ready, 1'b0);
      d1_reset = 1'b0;
      @(negedge clk);
      d1_seed_valid = 1'b1; d1_seed_lane = 1'b0; d1_gen_en = 1'b1; d1_out_ready = 1'b1;
      @(negedge clk);
      d1_seed_valid = 1'b0;
      chk("d1_seeded", d1_all_seeded, 1'b1);
      chk("d1_valid0", d1_out_valid, 1'b0);
      @(negedge clk);
      chk("d1_sample1", d1_out_data, 32'h0020_2080);
      chk("d1_cnt0", d1_sample_cnt, 32'd0);
      @(negedge clk);
      chk("d1_sample2", d1_out_data, 32'h0200_2C80);
      chk("d1_cnt1", d1_sample_cnt, 32'd1);
      d1_gen_en = 1'b0;
      @(negedge clk);
      chk("d1_cnt2", d1_sample_cnt, 32'd2);
      chk("d1_drained", d1_out_valid, 1'b0);

      // Out-of-range lane on the single-lane instance leaves the state alone
      t0 = st0(st0(32'd2)); t1 = st1(st1(32'd8)); t2 = st2(st2(32'd16));
      d1_seed_valid = 1'b1; d1_seed_lane = 1'b1;
      d1_seed_s0 = 32'h1111_1111; d1_seed_s1 = 32'h2222_2222; d1_seed_s2 = 32'h3333_3333;
      @(negedge clk);
      d1_seed_valid = 1'b0; d1_gen_en = 1'b1;
      @(negedge clk);
      d1_gen_en = 1'b0;
      chk("d1_oor_lane", d1_out_data, st0(t0) ^ st1(t1) ^ st2(t2));

      // Seed-correction table
      tbl[0] = '{32'd0, 32'd0, 32'd0, 32'h0020_2080};
      tbl[1] = '{32'd2, 32'd8, 32'd16, 32'h0020_2080};
      tbl[2] = '{32'd1, 32'd7, 32'd15, first_sample(32'd3, 32'd15, 32'd31)};
      tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      tbl[3].exp = first_sample(tbl[3].s0, tbl[3].s1, tbl[3].s2);
      tbl[4] = '{$urandom, $urandom, $urandom, 32'd0};
      tbl[4].exp = first_sample(tbl[4].s0, tbl[4].s1, tbl[4].s2);
      for (int i = 0; i < 5; i++) begin
         d1_seed_valid = 1'b1; d1_seed_lane = 1'b0;
         d1_seed_s0 = tbl[i].s0; d1_seed_s1 = tbl[i].s1; d1_seed_s2 = tbl[i].s2;
         @(negedge clk);
         d1_seed_valid = 1'b0; d1_gen_en = 1'b1;
         @(negedge clk);
         d1_gen_en = 1'b0;
         chk($sformatf("tbl%0d_valid", i), d1_out_valid, 1'b1);
         chk($sformatf("tbl%0d_sample", i), d1_out_data, tbl[i].exp);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
